// File: rtl/u_divider.sv
// u_divider: iterative unsigned restoring divider.
//
// One quotient bit is produced per clock in RUN, so a division with a
// non-zero divisor takes WIDTH RUN cycles. A zero divisor skips RUN and
// goes straight to DONE with the saturated result (Q = all ones, R = A,
// dbz = 1).
//
// Handshake: start is a request qualified only by the FSM. It is accepted
// on a rising edge when the block is in IDLE and reset is low. In every
// other state it is ignored. A and B are sampled only on the accepting
// edge. done is a one-cycle completion strobe during which Q/R/dbz are
// valid. Q/R/dbz then hold until the next completion. There is no
// back-pressure on done.
module u_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [1:0]       state_dbg
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] ITER_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] ITER_ONE  = CW'(1);

  // FSM state.
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  // Iteration datapath.
  // dvd starts as the dividend and fills with quotient bits from the right.
  // div holds the captured divisor for the whole operation.
  // rem is the partial remainder. It is always < div, so WIDTH bits suffice
  // for storage. The shift/subtract below is done at WIDTH+1 bits.
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    count;

  // Combinational step signals.
  logic             accept;
  logic             b_zero;
  logic             last_step;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_step;

  // Request qualification: only IDLE accepts a new operation.
  // Reset is asynchronous, so no edge with reset high ever reaches here.
  assign accept    = (state == ST_IDLE) && start;
  assign b_zero    = (B == '0);
  assign last_step = (count == ITER_ONE);

  // One restoring step.
  // 1. Shift {rem, dvd} left by one.
  // 2. Trial-subtract the divisor at WIDTH+1 bits.
  // Bit WIDTH of the trial result is the borrow. When the borrow is clear,
  // the subtraction fits: keep the difference and shift in a quotient 1.
  // Otherwise restore the shifted value and shift in a quotient 0.
  always_comb begin
    shifted  = {rem, dvd[WIDTH-1]};
    trial    = shifted - {1'b0, div};
    fits     = ~trial[WIDTH];
    rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_step = {dvd[WIDTH-2:0], fits};
  end

  // Next-state decode for the IDLE -> RUN/DONE -> IDLE sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = b_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on accept, then one shift/subtract per RUN cycle.
  // The loaded value WIDTH makes RUN last exactly WIDTH edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd   <= '0;
      div   <= '0;
      rem   <= '0;
      count <= '0;
    end else if (accept) begin
      dvd   <= A;
      div   <= B;
      rem   <= '0;
      count <= ITER_LOAD;
    end else if (state == ST_RUN) begin
      dvd   <= dvd_step;
      rem   <= rem_next;
      count <= count - ITER_ONE;
    end
  end

  // Result registers: loaded on the same edge that enters DONE.
  // A zero divisor enters DONE directly from the accepting edge. A normal
  // division enters DONE from the final RUN step, whose step outputs are
  // the finished quotient and remainder. At all other times Q/R/dbz hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q   <= '0;
      R   <= '0;
      dbz <= 1'b0;
    end else if (accept && b_zero) begin
      Q   <= '1;
      R   <= A;
      dbz <= 1'b1;
    end else if ((state == ST_RUN) && last_step) begin
      Q   <= dvd_step;
      R   <= rem_next;
      dbz <= 1'b0;
    end
  end

  // Status flags are plain decodes of the registered state.
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_u_divider.sv
// tb_u_divider: directed bench for u_divider, plus a short random sweep
// checked against the division identity.
module tb_u_divider;

  localparam int W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  u_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .A         (A),
    .B         (B),
    .Q         (Q),
    .R         (R),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .state_dbg (state_dbg)
  );

  // Clock and overall time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no summary expected finish before time limit");
    $fatal(1, "time limit reached");
  end

  // Comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a start pulse at the current point (caller is at a negedge).
  // Return #1 after the accepting edge.
  task automatic arm_op(input logic [W-1:0] a, input logic [W-1:0] b);
    A = a;
    B = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after the accepting edge until done is seen (bounded).
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    arm_op(a, b);
    wait_done(lat, busy_n);
  endtask

  // done must drop after exactly one cycle, back in IDLE.
  task automatic finish_op(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_low"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  initial begin
    int lat;
    int busy_n;
    int ndone;
    logic [W-1:0] q_seen;
    logic [W-1:0] r_seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    #1;
    check("rst_q", 64'(Q), 64'd0);
    check("rst_r", 64'(R), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(dbz), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(ST_IDLE));

    // start with reset held must not be accepted.
    @(negedge clk);
    start = 1'b1;
    A = 32'd8;
    B = 32'd2;
    @(posedge clk);
    #1;
    check("rst_no_accept", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // 8 / 2.
    run_op(32'd8, 32'd2, lat, busy_n);
    check("op8_2_lat", 64'(lat), 64'd32);
    check("op8_2_busy", 64'(busy_n), 64'd32);
    check("op8_2_q", 64'(Q), 64'd4);
    check("op8_2_r", 64'(R), 64'd0);
    check("op8_2_dbz", 64'(dbz), 64'd0);
    finish_op("op8_2");

    // 100 / 7.
    run_op(32'd100, 32'd7, lat, busy_n);
    check("op100_7_q", 64'(Q), 64'd14);
    check("op100_7_r", 64'(R), 64'd2);
    finish_op("op100_7");

    // 0xFFFFFFFF / 1.
    run_op(32'hFFFF_FFFF, 32'd1, lat, busy_n);
    check("opmax_1_q", 64'(Q), 64'hFFFF_FFFF);
    check("opmax_1_r", 64'(R), 64'd0);
    finish_op("opmax_1");

    // 5 / 9.
    run_op(32'd5, 32'd9, lat, busy_n);
    check("op5_9_q", 64'(Q), 64'd0);
    check("op5_9_r", 64'(R), 64'd5);
    finish_op("op5_9");

    // Largest operands on both sides.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, busy_n);
    check("opmax_max_q", 64'(Q), 64'd1);
    check("opmax_max_r", 64'(R), 64'd0);
    finish_op("opmax_max");

    // Zero dividend keeps normal latency.
    run_op(32'd0, 32'd5, lat, busy_n);
    check("op0_5_lat", 64'(lat), 64'd32);
    check("op0_5_q", 64'(Q), 64'd0);
    check("op0_5_r", 64'(R), 64'd0);
    finish_op("op0_5");

    // Divide by zero: done right after the accepting edge, never busy.
    run_op(32'd1234, 32'd0, lat, busy_n);
    check("dbz_lat", 64'(lat), 64'd0);
    check("dbz_busy", 64'(busy_n), 64'd0);
    check("dbz_busy_now", 64'(busy), 64'd0);
    check("dbz_q", 64'(Q), 64'hFFFF_FFFF);
    check("dbz_r", 64'(R), 64'd1234);
    check("dbz_flag", 64'(dbz), 64'd1);
    finish_op("dbz");

    // The divide-by-zero flag clears on the next normal completion.
    run_op(32'd9, 32'd3, lat, busy_n);
    check("op9_3_q", 64'(Q), 64'd3);
    check("op9_3_r", 64'(R), 64'd0);
    check("op9_3_dbz", 64'(dbz), 64'd0);
    finish_op("op9_3");

    // 40 / 3 with a stray start (99 / 9) during RUN.
    @(negedge clk);
    arm_op(32'd40, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    A = 32'd99;
    B = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", 64'(busy), 64'd1);
    ndone = 0;
    q_seen = '0;
    r_seen = '0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ndone++;
        q_seen = Q;
        r_seen = R;
      end
      @(posedge clk);
      #1;
    end
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_q", 64'(q_seen), 64'd13);
    check("ign_r", 64'(r_seen), 64'd1);
    check("ign_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Reset at RUN cycle 10 of 8 / 2 aborts without a done pulse.
    @(negedge clk);
    arm_op(32'd8, 32'd2);
    repeat (9) @(posedge clk);
    #3;
    check("abort_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_q", 64'(Q), 64'd0);
    check("abort_r", 64'(R), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_dbz", 64'(dbz), 64'd0);
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
      if (busy) busy_n++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_no_busy", 64'(busy_n), 64'd0);

    // start presented with reset deassertion is accepted on the first edge.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    arm_op(32'd8, 32'd2);
    check("post_rst_accept", 64'(state_dbg), 64'(ST_RUN));
    wait_done(lat, busy_n);
    check("post_rst_lat", 64'(lat), 64'd32);
    check("post_rst_q", 64'(Q), 64'd4);
    check("post_rst_r", 64'(R), 64'd0);
    finish_op("post_rst");

    // start held high: a new operation starts on the first IDLE edge after done.
    @(negedge clk);
    A = 32'd6;
    B = 32'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(lat, busy_n);
    check("held_lat", 64'(lat), 64'd32);
    check("held_q", 64'(Q), 64'd1);
    check("held_r", 64'(R), 64'd2);
    @(posedge clk);
    #1;
    check("held_idle", 64'(state_dbg), 64'(ST_IDLE));
    check("held_idle_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("held_restart", 64'(busy), 64'd1);
    wait_done(lat, busy_n);
    check("held2_lat", 64'(lat), 64'd32);
    check("held2_q", 64'(Q), 64'd1);
    check("held2_r", 64'(R), 64'd2);
    finish_op("held2");

    // Results hold while the operand inputs wander without start.
    A = 32'd77;
    B = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    check("hold_q", 64'(Q), 64'd1);
    check("hold_r", 64'(R), 64'd2);
    check("hold_dbz", 64'(dbz), 64'd0);
    check("hold_idle", 64'(state_dbg), 64'(ST_IDLE));

    // Random operands checked against the division identity.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? W'($urandom_range(1, 255)) : $urandom;
      if (i % 8 == 1) ra = W'($urandom_range(0, 1000));
      if (rb == '0) rb = 32'd1;
      run_op(ra, rb, lat, busy_n);
      check("rand_lat", 64'(lat), 64'd32);
      check("rand_ident", 64'(Q) * 64'(rb) + 64'(R), 64'(ra));
      check("rand_rlt", 64'(R < rb), 64'd1);
      check("rand_q", 64'(Q), 64'(ra / rb));
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
